button_event_decoder: RTL

- Consumes the debounced button level from the front-panel debouncer and turns it into single-cycle user-interface events: press, release, tap, double-tap, long-press, and auto-repeat while held.
- Sits between the debouncer output and the effect-control logic (preset select, bypass toggle, parameter step).
- It reads the interface that the debouncer writes.

---
 rtl/ui_pkg.sv | 21 ++
 rtl/ui_tick_timer.sv | 28 ++
 rtl/button_event_decoder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ui_pkg.sv
// Shared types and default timing for the front-panel button event decoder.
// Default tick counts assume the 38 MHz system clock.
package ui_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOWN1 = 3'd1,
        WAIT2 = 3'd2,
        DOWN2 = 3'd3,
        LONG  = 3'd4
    } ui_state_t;

    localparam int SYS_CLK_HZ = 38_000_000;

    // 12M ticks is about 316 ms, 9M about 237 ms, 4M about 105 ms at 38 MHz.
    localparam int DEF_CNT_W        = 24;
    localparam int DEF_LONG_TICKS   = 12_000_000;
    localparam int DEF_DTAP_TICKS   = 9_000_000;
    localparam int DEF_REPEAT_TICKS = 4_000_000;

endpackage

// File: rtl/ui_tick_timer.sv
// Shared tick counter for the decoder FSM.
// It clears, increments and flags when the count equals the limit selected by the FSM.
module ui_tick_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hit = (cnt == limit);

endmodule

// File: rtl/button_event_decoder.sv
// Converts the debounced button level into single-cycle events.
// The events are press, release, tap, double-tap, long-press and auto-repeat.
module button_event_decoder
    import ui_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int DTAP_TICKS   = DEF_DTAP_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic db_in,
    input  logic enable,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic tap_pulse,
    output logic dtap_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DTAP_LIM   = CNT_W'(DTAP_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_TICKS - 1);

    ui_state_t        state;
    ui_state_t        state_nxt;
    logic             lvl;
    logic             lvl_q;
    logic             pe;
    logic             ne;
    logic             timer_clr;
    logic             timer_inc;
    logic [CNT_W-1:0] limit;
    logic             hit;
    logic             press_nxt;
    logic             release_nxt;
    logic             tap_nxt;
    logic             dtap_nxt;
    logic             long_nxt;
    logic             repeat_nxt;

    assign lvl  = db_in ^ ACTIVE_LOW;
    assign pe   = lvl & ~lvl_q;
    assign ne   = ~lvl & lvl_q;
    assign held = lvl_q;

    ui_tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clr),
        .inc   (timer_inc),
        .limit (limit),
        .hit   (hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            lvl_q         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            tap_pulse     <= 1'b0;
            dtap_pulse    <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_nxt;
            lvl_q         <= lvl;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            tap_pulse     <= tap_nxt;
            dtap_pulse    <= dtap_nxt;
            long_pulse    <= long_nxt;
            repeat_pulse  <= repeat_nxt;
        end
    end

    // Edges are tested before timeouts so an edge wins a same-cycle tie.
    always_comb begin
        state_nxt = state;
        limit     = LONG_LIM;
        case (state)
            IDLE: begin
                if (pe) state_nxt = DOWN1;
            end
            DOWN1: begin
                if (ne)       state_nxt = WAIT2;
                else if (hit) state_nxt = LONG;
            end
            WAIT2: begin
                limit = DTAP_LIM;
                if (pe)       state_nxt = DOWN2;
                else if (hit) state_nxt = IDLE;
            end
            DOWN2: begin
                if (ne)       state_nxt = IDLE;
                else if (hit) state_nxt = LONG;
            end
            LONG: begin
                limit = REPEAT_LIM;
                if (ne) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!enable) state_nxt = IDLE;

        // The counter restarts on any state change, each repeat period, and whenever idle.
        timer_clr = (state_nxt != state) || (state_nxt == IDLE) || (state == LONG && hit);
        timer_inc = ~timer_clr;
    end

    always_comb begin
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        tap_nxt     = 1'b0;
        dtap_nxt    = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        if (enable) begin
            case (state)
                IDLE: press_nxt = pe;
                DOWN1: begin
                    release_nxt = ne;
                    long_nxt    = ~ne & hit;
                end
                WAIT2: begin
                    press_nxt = pe;
                    tap_nxt   = ~pe & hit;
                end
                DOWN2: begin
                    release_nxt = ne;
                    dtap_nxt    = ne;
                    long_nxt    = ~ne & hit;
                end
                LONG: begin
                    release_nxt = ne;
                    repeat_nxt  = ~ne & hit;
                end
                default: press_nxt = 1'b0;
            endcase
        end
    end

endmodule
